apb_req_arbiter: RTL
====================

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: cycles WAIT may last before abort; legal range 2..255.
REQ-002 pclk  input  1  sole clock; all state updates on rising edge.
REQ-003 preset  input  1  reset; one clock (pclk), reset synchronous and active-high.
REQ-004 req_i  input  4  per-requester transaction request; bit n = requester n.
REQ-005 req_wr_i  input  4  per-requester direction; 1 = write, 0 = read; sampled with req_i.
REQ-006 transfer_o  output  2  command to APB master; 00 idle, 01 read, 11 write.
REQ-007 psel_i  input  1  master psel_o.
REQ-008 penable_i  input  1  master penable_o.
REQ-009 pready_i  input  1  slave ready, same net the master sees.
REQ-010 prdata_i  input  8  slave read data.
REQ-011 gnt_o  output  4  one-hot grant; high from grant through DONE.
REQ-012 done_o  output  4  one-cycle completion pulse to granted requester.
REQ-013 rdata_o  output  8  read data of last completed read; holds until next read completes.
REQ-014 err_o  output  1  one-cycle pulse, coincident with done_o, marking aborted transaction.

Function
REQ-015 FSM states IDLE, ISSUE, WAIT, DONE; one state per cycle except WAIT.
REQ-016 IDLE: req_i == 0 -> stay; else grant highest-priority set bit under round-robin, latch req_wr_i of winner, go ISSUE.
REQ-017 Round-robin: pointer p (2 bits); search order p, p+1, p+2, p+3 mod 4; after DONE p = granted index + 1 mod 4.
REQ-018 ISSUE: transfer_o = {latched_wr, 1} for exactly one cycle; then WAIT; transfer_o = 00 in every other state.
REQ-019 WAIT: completion when psel_i && penable_i && pready_i sampled high -> go DONE; on read, rdata_o <= prdata_i at that edge.
REQ-020 DONE: done_o[granted] = 1 for one cycle, gnt_o still set; next state IDLE, gnt_o cleared.
REQ-021 Grant-to-next-grant minimum 4 cycles (IDLE, ISSUE, >=1 WAIT, DONE); no back-to-back ISSUE.
REQ-022 req_i of granted requester dropping after grant does not cancel; transaction completes, done_o still pulses.
REQ-023 req_i changes of non-granted requesters ignored outside IDLE.
REQ-024 Write completion leaves rdata_o unchanged.
REQ-025 Simultaneous requests: exactly one winner per REQ-017; losers wait, no request lost while held.
REQ-026 gnt_o always one-hot or zero; done_o only asserts on the bit set in gnt_o.

Reset
REQ-027 preset high at an edge: state IDLE, p = 0, transfer_o = 00, gnt_o = 0, done_o = 0, rdata_o = 00, err_o = 0, timeout counter 0.
REQ-028 Reset mid-transaction aborts with no done_o or err_o pulse; first grant after release follows p = 0.
REQ-029 Outputs valid from first edge with preset high; no X after that edge.

Configuration
REQ-030 Macro APB_ARB_TIMEOUT_EN defined: WAIT counts cycles; count reaching TIMEOUT_CYCLES without completion -> go DONE with err_o = 1, rdata_o unchanged, pointer advances normally.
REQ-031 Macro APB_ARB_TIMEOUT_EN undefined: no counter logic, WAIT unbounded, err_o tied 0, port retained.

Verification
REQ-032 Reset 2 cycles, req_i = 0001, req_wr_i = 0 -> transfer_o = 01 one cycle, gnt_o = 0001, slave pready with prdata 8'h5A -> done_o = 0001 one cycle, rdata_o = 5A.
REQ-033 req_i = 1111 held, all reads, pready after one WAIT cycle -> grants 0001, 0010, 0100, 1000, 0001 in order, each done_o one cycle.
REQ-034 req_i = 0100, req_wr_i = 0100 -> transfer_o = 11; completion -> done_o = 0100, rdata_o unchanged from prior read.
REQ-035 Timeout build, TIMEOUT_CYCLES = 16, pready_i held 0 -> 16 WAIT cycles then done_o and err_o pulse together, next IDLE; non-timeout build stays in WAIT 100 cycles.
REQ-036 preset asserted during WAIT with gnt_o = 0010 -> next edge all outputs per REQ-027, no done_o; after release req_i = 1010 grants 0010 first (p = 0).

Source files
------------

// File: rtl/apb_req_arbiter_if.sv
// Requester and APB-monitor bundle for apb_req_arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface apb_req_arbiter_if;
  logic [3:0] req_i;
  logic [3:0] req_wr_i;
  logic [1:0] transfer_o;
  logic       psel_i;
  logic       penable_i;
  logic       pready_i;
  logic [7:0] prdata_i;
  logic [3:0] gnt_o;
  logic [3:0] done_o;
  logic [7:0] rdata_o;
  logic       err_o;

  modport slave (
    input  req_i, req_wr_i, psel_i, penable_i, pready_i, prdata_i,
    output transfer_o, gnt_o, done_o, rdata_o, err_o
  );

  modport master (
    output req_i, req_wr_i, psel_i, penable_i, pready_i, prdata_i,
    input  transfer_o, gnt_o, done_o, rdata_o, err_o
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Four-requester round-robin arbiter that issues one APB transfer at a time.
// Optional WAIT timeout is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_req_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic              pclk,
  input logic              preset,
  apb_req_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t     state_reg;
  logic [1:0] ptr_reg;
  logic [1:0] idx_reg;
  logic       wr_reg;
  logic [1:0] transfer_reg;
  logic [3:0] gnt_reg;
  logic [3:0] done_reg;
  logic [7:0] rdata_reg;

  logic [3:0] hit;
  logic [1:0] win_off;
  logic [1:0] win_idx;
  logic       complete;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_req_arbiter: TIMEOUT_CYCLES must be within 2..255");
  end

  // hit[gi] is the request of the requester gi places after the pointer
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_rot
    assign hit[gi] = bus.req_i[2'(ptr_reg + 2'(gi))];
  end

  always_comb begin
    win_off = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (hit[k]) win_off = 2'(k);
    end
  end

  assign win_idx  = 2'(ptr_reg + win_off);
  assign complete = bus.psel_i && bus.penable_i && bus.pready_i;

`ifdef APB_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_reg;
  logic       err_reg;
`endif

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_reg    <= IDLE;
      ptr_reg      <= 2'd0;
      idx_reg      <= 2'd0;
      wr_reg       <= 1'b0;
      transfer_reg <= 2'b00;
      gnt_reg      <= 4'd0;
      done_reg     <= 4'd0;
      rdata_reg    <= 8'd0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_reg      <= 8'd0;
      err_reg      <= 1'b0;
`endif
    end else begin
      done_reg <= 4'd0;
`ifdef APB_ARB_TIMEOUT_EN
      err_reg  <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (|bus.req_i) begin
            state_reg    <= ISSUE;
            idx_reg      <= win_idx;
            wr_reg       <= bus.req_wr_i[win_idx];
            gnt_reg      <= 4'b0001 << win_idx;
            transfer_reg <= {bus.req_wr_i[win_idx], 1'b1};
          end
        end
        ISSUE: begin
          state_reg    <= WAIT;
          transfer_reg <= 2'b00;
`ifdef APB_ARB_TIMEOUT_EN
          cnt_reg      <= 8'd0;
`endif
        end
        WAIT: begin
          if (complete) begin
            state_reg <= DONE;
            done_reg  <= gnt_reg;
            if (!wr_reg) rdata_reg <= bus.prdata_i;
          end
`ifdef APB_ARB_TIMEOUT_EN
          // completion on the final allowed cycle still wins over the abort
          else if (cnt_reg == TIMEOUT_LAST) begin
            state_reg <= DONE;
            done_reg  <= gnt_reg;
            err_reg   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
`endif
        end
        DONE: begin
          state_reg <= IDLE;
          gnt_reg   <= 4'd0;
          ptr_reg   <= 2'(idx_reg + 2'd1);
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.transfer_o = transfer_reg;
  assign bus.gnt_o      = gnt_reg;
  assign bus.done_o     = done_reg;
  assign bus.rdata_o    = rdata_reg;
`ifdef APB_ARB_TIMEOUT_EN
  assign bus.err_o      = err_reg;
`else
  assign bus.err_o      = 1'b0;
`endif
endmodule
